fraction_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one fraction_multiplier4 datapath among NREQ requesters.
- Selects a requester, latches its 4-bit fraction operands and pulses St to the multiplier.
- Waits for Done, then returns the 7-bit Product to the winning requester over a valid/ack handshake.
- Sits between client blocks and the single multiplier instance; the multiplier has no reset, so this block also owns its post-reset settling.

---
 rtl/fraction_mult_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fraction_mult_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fraction_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fraction_multiplier4 among NREQ clients.
// Build option MUL_TIMEOUT_EN adds a BUSY watchdog that aborts a stuck multiply with rsp_err.
module fraction_mult_arbiter #(
    parameter int NREQ           = 4,
    parameter int SETTLE_CYCLES  = 12,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_mplier,
    input  logic [4*NREQ-1:0]   req_mcand,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ack,
    output logic [6:0]          rsp_product,
    output logic                rsp_err,
    output logic                mul_St,
    output logic [3:0]          mul_Mplier,
    output logic [3:0]          mul_Mcand,
    input  logic [6:0]          mul_Product,
    input  logic                mul_Done,
    output logic [2:0]          dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [IW:0]   NREQ_W      = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_SETTLE = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_BUSY   = 3'd3,
        S_RESP   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_settle_cnt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;

    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;
    logic [IW-1:0]     w_pick;
    logic              w_found;
    logic [3:0]        w_mplier_arr [NREQ];
    logic [3:0]        w_mcand_arr  [NREQ];

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_ops
            assign w_mplier_arr[g] = req_mplier[4*g +: 4];
            assign w_mcand_arr[g]  = req_mcand[4*g +: 4];
        end
    endgenerate

    // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_req_rot = w_req_dbl[NREQ-1:0];
    assign w_found   = |req;

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) w_off = IW'(k);
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick    = (w_sum >= NREQ_W) ? IW'(w_sum - NREQ_W) : w_sum[IW-1:0];
    assign dbg_state = r_state;

`ifdef MUL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_busy_cnt;
    logic       r_err;
    logic       r_timed_out;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Handshakes: gnt is a one-cycle pulse meaning the operands were captured;
    // rsp_valid holds with rsp_product until the matching rsp_ack bit is seen high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
            r_ptr        <= '0;
            r_idx        <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_product  <= '0;
            mul_St       <= 1'b0;
            mul_Mplier   <= '0;
            mul_Mcand    <= '0;
`ifdef MUL_TIMEOUT_EN
            r_busy_cnt   <= '0;
            r_err        <= 1'b0;
            r_timed_out  <= 1'b0;
`endif
        end else begin
            gnt    <= '0;
            mul_St <= 1'b0;
            case (r_state)
                S_SETTLE: begin
                    // The multiplier has no reset; it must be idle before it can accept St.
                    if (r_settle_cnt != SETTLE_LAST) begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end else if (!mul_Done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_found) begin
                        mul_Mplier <= w_mplier_arr[w_pick];
                        mul_Mcand  <= w_mcand_arr[w_pick];
                        r_idx      <= w_pick;
                        gnt        <= onehot(w_pick);
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (!mul_Done) begin
                        mul_St  <= 1'b1;
                        r_state <= S_BUSY;
`ifdef MUL_TIMEOUT_EN
                        r_busy_cnt <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (mul_Done) begin
                        rsp_product <= mul_Product;
                        rsp_valid   <= onehot(r_idx);
                        r_state     <= S_RESP;
`ifdef MUL_TIMEOUT_EN
                    end else if (r_busy_cnt == TIMEOUT_LAST) begin
                        rsp_product <= '0;
                        rsp_valid   <= onehot(r_idx);
                        r_err       <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (|(rsp_ack & rsp_valid)) begin
                        rsp_valid <= '0;
                        r_ptr     <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
`ifdef MUL_TIMEOUT_EN
                        r_err <= 1'b0;
                        if (r_timed_out) begin
                            r_timed_out  <= 1'b0;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
`else
                        r_state <= S_DRAIN;
`endif
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                default: r_state <= S_SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fraction_mult_arbiter.sv
// Directed bench for fraction_mult_arbiter with a behavioural fraction_multiplier4 peer.
// Also exercises the MUL_TIMEOUT_EN watchdog when that macro is defined.
module tb_fraction_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int SETTLE  = 12;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 4;
    localparam int BOUND   = 200;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] req_mplier = '0;
    logic [4*NREQ-1:0] req_mcand = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ack = '0;
    logic [6:0]        rsp_product;
    logic              rsp_err;
    logic              mul_St;
    logic [3:0]        mul_Mplier;
    logic [3:0]        mul_Mcand;
    logic [6:0]        mul_Product = '0;
    logic              mul_Done = 1'b0;
    logic [2:0]        dbg_state;

    fraction_mult_arbiter #(
        .NREQ(NREQ), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_mplier(req_mplier), .req_mcand(req_mcand),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_product(rsp_product),
        .rsp_err(rsp_err), .mul_St(mul_St), .mul_Mplier(mul_Mplier), .mul_Mcand(mul_Mcand),
        .mul_Product(mul_Product), .mul_Done(mul_Done), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // ---------------- multiplier model (no reset, like the real one) ----------------
    logic              m_busy = 1'b0;
    int                m_cnt  = 0;
    logic signed [3:0] m_a = '0;
    logic signed [3:0] m_b = '0;
    logic              m_hang = 1'b0;
    logic signed [7:0] m_full;
    assign m_full = 8'(m_a) * 8'(m_b);

    always @(posedge CLK) begin
        if (m_busy) begin
            if (m_cnt == LAT - 1) begin
                mul_Done    <= 1'b1;
                mul_Product <= m_full[6:0];
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (mul_Done) begin
            mul_Done <= 1'b0;
        end else if (mul_St && !m_hang) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_a    <= mul_Mplier;
            m_b    <= mul_Mcand;
        end
    end

    // ---------------- scoreboard counters and monitor ----------------
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int st_first = -1;
    int overlap = 0;

    always @(negedge CLK) begin
        if (RST) cyc = 0;
        else cyc = cyc + 1;
        if (mul_St && st_first < 0) st_first = cyc;
        if (gnt != '0 && rsp_valid != '0 && gnt != rsp_valid) overlap = overlap + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic wait_gnt();
        int n;
        n = 0;
        while (gnt == '0 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic wait_rsp(output int st_seen, output int gnt_seen);
        int n;
        n = 0;
        st_seen = 0;
        gnt_seen = 0;
        while (rsp_valid == '0 && n < BOUND) begin
            @(negedge CLK);
            n++;
            if (mul_St) st_seen++;
            if (gnt != '0) gnt_seen++;
        end
    endtask

    task automatic ack_now(input string tag);
        rsp_ack = rsp_valid;
        @(negedge CLK);
        rsp_ack = '0;
        check({tag, "_cleared"}, 32'(rsp_valid), 32'h0);
    endtask

    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [6:0] exp, input string tag);
        int st_seen, gnt_seen;
        req_mplier[idx*4 +: 4] = a;
        req_mcand[idx*4 +: 4]  = b;
        req[idx] = 1'b1;
        wait_gnt();
        check({tag, "_gnt"}, 32'(gnt), 32'(oh(idx)));
        req[idx] = 1'b0;
        wait_rsp(st_seen, gnt_seen);
        check({tag, "_st_once"}, 32'(st_seen), 32'd1);
        check({tag, "_no_extra_gnt"}, 32'(gnt_seen), 32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'(oh(idx)));
        check({tag, "_product"}, 32'(rsp_product), 32'(exp));
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        ack_now(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(gnt), 32'h0);
        check({tag, "_valid0"}, 32'(rsp_valid), 32'h0);
        check({tag, "_product0"}, 32'(rsp_product), 32'h0);
        check({tag, "_err0"}, 32'(rsp_err), 32'h0);
        check({tag, "_st0"}, 32'(mul_St), 32'h0);
        check({tag, "_mplier0"}, 32'(mul_Mplier), 32'h0);
        check({tag, "_mcand0"}, 32'(mul_Mcand), 32'h0);
        check({tag, "_state_settle"}, 32'(dbg_state), 32'h0);
    endtask

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs[6];
        int   order[5];
        int   st_seen, gnt_seen, bad_hold, bad_quiet, n;

        // Hand-computed Q1.3 x Q1.3 -> Q1.6 products
        vecs[0] = '{0, 4'b0100, 4'b0100, 7'h10};  //  0.5   *  0.5   =  0.25
        vecs[1] = '{2, 4'b1100, 4'b0100, 7'h70};  // -0.5   *  0.5   = -0.25
        vecs[2] = '{1, 4'b0111, 4'b0010, 7'h0E};  //  0.875 *  0.25  =  0.21875
        vecs[3] = '{3, 4'b1000, 4'b0100, 7'h60};  // -1.0   *  0.5   = -0.5
        vecs[4] = '{1, 4'b1100, 4'b1100, 7'h10};  // -0.5   * -0.5   =  0.25
        vecs[5] = '{3, 4'b0110, 4'b0110, 7'h24};  //  0.75  *  0.75  =  0.5625
        order   = '{0, 1, 2, 3, 0};

        // Reset then single request (request already pending through reset)
        req = 4'b0001;
        req_mplier[3:0] = 4'b0100;
        req_mcand[3:0]  = 4'b0100;
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        run_op(0, 4'b0100, 4'b0100, 7'h10, "first");
        check("no_st_during_settle", 32'(st_first >= SETTLE), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Round-robin: all four pending, immediate acks; pointer starts at 0
        for (int i = 0; i < NREQ; i++) begin
            req_mplier[i*4 +: 4] = 4'b0010;
            req_mcand[i*4 +: 4]  = 4'b0100;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt();
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(oh(order[k])));
            if (k == 4) req = '0;
            wait_rsp(st_seen, gnt_seen);
            check($sformatf("rr_product%0d", k), 32'(rsp_product), 32'h08);
            ack_now($sformatf("rr%0d", k));
        end

        // Delayed ack with a second request pending; pointer now at 1
        req_mplier[7:4] = 4'b0100;  req_mcand[7:4] = 4'b0100;
        req_mplier[3:0] = 4'b0010;  req_mcand[3:0] = 4'b0100;
        req = 4'b0011;
        wait_gnt();
        check("delay_gnt1", 32'(gnt), 32'(oh(1)));
        req[1] = 1'b0;
        wait_rsp(st_seen, gnt_seen);
        check("delay_valid1", 32'(rsp_valid), 32'(oh(1)));
        bad_hold = 0;
        bad_quiet = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (rsp_valid != oh(1) || rsp_product != 7'h10) bad_hold++;
            if (mul_St || gnt != '0) bad_quiet++;
        end
        check("delay_stable", 32'(bad_hold), 32'd0);
        check("delay_no_new_op", 32'(bad_quiet), 32'd0);
        ack_now("delay1");
        wait_gnt();
        check("delay_gnt0", 32'(gnt), 32'(oh(0)));
        req = '0;
        wait_rsp(st_seen, gnt_seen);
        check("delay_product0", 32'(rsp_product), 32'h08);
        ack_now("delay0");

        // Reset in the middle of a multiply
        req_mplier[11:8] = 4'b0111;
        req_mcand[11:8]  = 4'b0111;
        req[2] = 1'b1;
        wait_gnt();
        req = '0;
        n = 0;
        while (!mul_St && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("midrst_st_seen", 32'(mul_St), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_all_zero("midrst");
        RST = 1'b0;
        bad_hold = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (rsp_valid != '0) bad_hold++;
        end
        check("midrst_no_rsp", 32'(bad_hold), 32'd0);
        run_op(2, 4'b1100, 4'b0100, 7'h70, "after_rst");

`ifdef MUL_TIMEOUT_EN
        // Stuck multiplier: Done never comes
        m_hang = 1'b1;
        req_mplier[7:4] = 4'b0100;
        req_mcand[7:4]  = 4'b0100;
        req[1] = 1'b1;
        wait_gnt();
        check("to_gnt", 32'(gnt), 32'(oh(1)));
        req = '0;
        n = 0;
        while (!mul_St && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (rsp_valid == '0 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        check("to_cycles", 32'(n), 32'(TIMEOUT));
        check("to_valid", 32'(rsp_valid), 32'(oh(1)));
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_product", 32'(rsp_product), 32'h0);
        ack_now("to");
        check("to_resettle", 32'(dbg_state), 32'h0);
        m_hang = 1'b0;
        run_op(1, 4'b0100, 4'b0100, 7'h10, "after_to");
`endif

        check("no_gnt_rsp_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
